// File: rtl/gen_mask_stream.sv
// Streaming window-mask generator: one SEQ_WIDTH-bit word per beat, MSB-first.
// Optional GEN_MASK_SKIP_EN: start emission at the first word touched by the window.
module gen_mask_stream #(
    parameter int SEQ_WIDTH = 40,
    parameter int MAX_WORDS = 4,
    parameter int POS_W     = 8,
    parameter int WORD_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [POS_W-1:0]     i_start,
    input  logic [POS_W-1:0]     i_len,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SEQ_WIDTH-1:0] o_mask,
    output logic [WORD_W-1:0]    o_word,
    output logic                 o_last
);

    localparam int CAP = SEQ_WIDTH * MAX_WORDS;
    localparam int K_W = $clog2(SEQ_WIDTH + 1);
    localparam int E_W = POS_W + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t            state_r;
    logic [E_W-1:0]    start_r;
    logic [E_W-1:0]    end_r;
    logic [E_W-1:0]    base_r;
    logic [WORD_W-1:0] last_word_r;

    logic [E_W-1:0]    start_ext_s;
    logic [E_W-1:0]    sum_s;
    logic [E_W-1:0]    end_s;
    logic [E_W-1:0]    end_m1_s;
    logic              empty_s;
    logic [WORD_W-1:0] last_s;
    logic [WORD_W-1:0] first_s;
    logic [E_W-1:0]    first_base_s;
    logic [E_W-1:0]    base_next_s;
    logic [WORD_W-1:0] word_next_s;

    // Position relative to the word base, clamped into [0, SEQ_WIDTH].
    function automatic logic [K_W-1:0] clamp_local(input logic [E_W-1:0] pos,
                                                   input logic [E_W-1:0] base);
        logic [E_W-1:0] d;
        d = pos - base;
        if (pos <= base) begin
            return '0;
        end else if (d >= E_W'(SEQ_WIDTH)) begin
            return K_W'(SEQ_WIDTH);
        end else begin
            return d[K_W-1:0];
        end
    endfunction

    function automatic logic [SEQ_WIDTH-1:0] word_mask(input logic [E_W-1:0] s,
                                                       input logic [E_W-1:0] e,
                                                       input logic [E_W-1:0] base);
        logic [K_W-1:0]       lo;
        logic [K_W-1:0]       hi;
        logic [SEQ_WIDTH-1:0] m;
        lo = clamp_local(s, base);
        hi = clamp_local(e, base);
        m  = '0;
        for (int k = 0; k < SEQ_WIDTH; k++) begin
            m[SEQ_WIDTH-1-k] = (K_W'(k) >= lo) && (K_W'(k) < hi);
        end
        return m;
    endfunction

    assign start_ext_s = {1'b0, i_start};
    assign sum_s       = start_ext_s + {1'b0, i_len};
    assign end_s       = (sum_s > E_W'(CAP)) ? E_W'(CAP) : sum_s;
    assign end_m1_s    = end_s - E_W'(1);
    assign empty_s     = (end_s <= start_ext_s);
    assign base_next_s = base_r + E_W'(SEQ_WIDTH);
    assign word_next_s = o_word + WORD_W'(1);
    assign o_ready     = (state_r == IDLE) && !rst;

    // Last and first word by threshold compare, so no divider is needed.
    always_comb begin
        last_s  = '0;
        first_s = '0;
        for (int w = 1; w < MAX_WORDS; w++) begin
            last_s = (end_m1_s >= E_W'(w * SEQ_WIDTH)) ? WORD_W'(w) : last_s;
`ifdef GEN_MASK_SKIP_EN
            first_s = (start_ext_s >= E_W'(w * SEQ_WIDTH)) ? WORD_W'(w) : first_s;
`endif
        end
        if (empty_s) begin
            last_s  = '0;
            first_s = '0;
        end else begin
            last_s  = last_s;
            first_s = first_s;
        end
        first_base_s = E_W'(first_s) * E_W'(SEQ_WIDTH);
    end

    // Request/beat FSM with registered beat outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            start_r     <= '0;
            end_r       <= '0;
            base_r      <= '0;
            last_word_r <= '0;
            o_valid     <= 1'b0;
            o_mask      <= '0;
            o_word      <= '0;
            o_last      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_valid) begin
                        start_r     <= start_ext_s;
                        end_r       <= end_s;
                        last_word_r <= last_s;
                        base_r      <= first_base_s;
                        o_word      <= first_s;
                        o_mask      <= word_mask(start_ext_s, end_s, first_base_s);
                        o_last      <= (first_s == last_s);
                        o_valid     <= 1'b1;
                        state_r     <= EMIT;
                    end
                end
                EMIT: begin
                    if (i_ready) begin
                        if (o_word == last_word_r) begin
                            o_valid <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            o_word <= word_next_s;
                            base_r <= base_next_s;
                            o_mask <= word_mask(start_r, end_r, base_next_s);
                            o_last <= (word_next_s == last_word_r);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gen_mask_stream.sv
// Directed self-checking bench for gen_mask_stream (default parameters).
module tb_gen_mask_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_start;
    logic [7:0]  i_len;
    logic        o_valid;
    logic        i_ready;
    logic [39:0] o_mask;
    logic [1:0]  o_word;
    logic        o_last;

    int total  = 0;
    int passed = 0;

    gen_mask_stream dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_start (i_start),
        .i_len   (i_len),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_mask  (o_mask),
        .o_word  (o_word),
        .o_last  (o_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Present a request in IDLE and let it be accepted on the next edge.
    task automatic request(input logic [7:0] s, input logic [7:0] l);
        chk("ready_idle", 64'(o_ready), 64'd1);
        i_start = s;
        i_len   = l;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_start = 8'd0;
        i_len   = 8'd0;
    endtask

    task automatic beat(input string tag, input logic [39:0] m, input logic [1:0] w,
                        input logic l);
        chk({tag, "_valid"}, 64'(o_valid), 64'd1);
        chk({tag, "_mask"}, 64'(o_mask), 64'(m));
        chk({tag, "_word"}, 64'(o_word), 64'(w));
        chk({tag, "_last"}, 64'(o_last), 64'(l));
        chk({tag, "_busy"}, 64'(o_ready), 64'd0);
        tick();
    endtask

    task automatic done(input string tag);
        chk({tag, "_done_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_done_ready"}, 64'(o_ready), 64'd1);
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_start = 8'd0;
        i_len   = 8'd0;
        i_ready = 1'b1;
        tick();
        tick();
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_mask", 64'(o_mask), 64'd0);
        chk("rst_word", 64'(o_word), 64'd0);
        chk("rst_last", 64'(o_last), 64'd0);
        rst = 1'b0;
        tick();

        // Full first word.
        request(8'd0, 8'd40);
        beat("full", 40'hFF_FFFF_FFFF, 2'd0, 1'b1);
        done("full");
        tick();

        // Window inside one word.
        request(8'd3, 8'd10);
        beat("mid", 40'h1F_F800_0000, 2'd0, 1'b1);
        done("mid");
        tick();

        // Straddles words 0/1 with 3 cycles of backpressure on beat 0.
        request(8'd35, 8'd10);
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat("hold", 40'h00_0000_001F, 2'd0, 1'b0);
        end
        i_ready = 1'b1;
        beat("span0", 40'h00_0000_001F, 2'd0, 1'b0);
        beat("span1", 40'hF8_0000_0000, 2'd1, 1'b1);
        done("span");
        tick();

        // Clipped at capacity.
        request(8'd150, 8'd50);
`ifndef GEN_MASK_SKIP_EN
        beat("clip0", 40'h0, 2'd0, 1'b0);
        beat("clip1", 40'h0, 2'd1, 1'b0);
        beat("clip2", 40'h0, 2'd2, 1'b0);
`endif
        beat("clip3", 40'h00_0000_03FF, 2'd3, 1'b1);
        done("clip");
        tick();

        // Zero length.
        request(8'd17, 8'd0);
        beat("zero", 40'h0, 2'd0, 1'b1);
        done("zero");
        tick();

        // Start beyond capacity is an empty window.
        request(8'd200, 8'd5);
        beat("beyond", 40'h0, 2'd0, 1'b1);
        done("beyond");
        tick();

        // Reset during beat 1 of a 3-beat burst.
        request(8'd0, 8'd120);
        beat("abort0", 40'hFF_FFFF_FFFF, 2'd0, 1'b0);
        chk("abort1_mask", 64'(o_mask), 64'(40'hFF_FFFF_FFFF));
        chk("abort1_word", 64'(o_word), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_rst_ready", 64'(o_ready), 64'd0);
        tick();
        chk("abort_valid", 64'(o_valid), 64'd0);
        chk("abort_mask", 64'(o_mask), 64'd0);
        chk("abort_last", 64'(o_last), 64'd0);
        rst = 1'b0;
        tick();
        chk("abort_no_beat", 64'(o_valid), 64'd0);
        request(8'd0, 8'd1);
        beat("after", 40'h80_0000_0000, 2'd0, 1'b1);
        done("after");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
